// File: rtl/io_pkg.sv
// Shared definitions for the IO input controller: scan states, register map
// and the default debounce depth.
package io_pkg;

  typedef enum logic [1:0] {
    SCAN_SW  = 2'd0,
    SCAN_KEY = 2'd1,
    SCAN_AX  = 2'd2
  } scan_state_t;

  localparam logic [5:0] ADDR_SW     = 6'b100000;
  localparam logic [5:0] ADDR_KEY    = 6'b100001;
  localparam logic [5:0] ADDR_AX     = 6'b100100;
  localparam logic [5:0] ADDR_STATUS = 6'b100101;

  localparam int DEB_CYCLES_DEF = 4;

  function automatic scan_state_t next_scan(input scan_state_t s);
    case (s)
      SCAN_SW:  return SCAN_KEY;
      SCAN_KEY: return SCAN_AX;
      default:  return SCAN_SW;
    endcase
  endfunction

endpackage

// File: rtl/io_read_mux.sv
// Word-address decode of the latched input registers and change flags into
// the CPU read-data bus.
module io_read_mux
  import io_pkg::*;
(
  input  logic [5:0]  addr_sel,
  input  logic [9:0]  sw_lat,
  input  logic [3:0]  key_lat,
  input  logic [31:0] ax_lat,
  input  logic [2:0]  chg,
  output logic [31:0] read_data
);

  always_comb begin
    read_data = '0;
    case (addr_sel)
      ADDR_SW:     read_data = {22'b0, sw_lat};
      ADDR_KEY:    read_data = {28'b0, key_lat};
      ADDR_AX:     read_data = ax_lat;
      ADDR_STATUS: read_data = {29'b0, chg};
      default:     read_data = '0;
    endcase
  end

endmodule

// File: rtl/io_input_ctrl.sv
// Round-robin debouncing scanner for the switch, key and external input banks,
// with per-port change flags cleared by CPU reads.
module io_input_ctrl
  import io_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DWELL_MAX  = 4 * DEB_CYCLES
)(
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic        io_rd,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  input  logic [31:0] ax,
  output logic [31:0] io_read_data,
  output logic [2:0]  io_chg
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_MAX - 1);

  scan_state_t      state;
  logic             entry;
  logic [31:0]      cand;
  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] dwell_cnt;
  logic [9:0]       sw_lat;
  logic [3:0]       key_lat;
  logic [31:0]      ax_lat;

  logic [31:0]      raw;
  logic [31:0]      lat_cur;
  logic [CNT_W-1:0] stab_inc;
  logic [CNT_W-1:0] dwell_inc;
  logic             commit;
  logic [2:0]       set_mask;
  logic [2:0]       clr_mask;
  logic             unused_addr;

  assign unused_addr = ^{addr[31:8], addr[1:0]};

  always_comb begin
    raw     = '0;
    lat_cur = '0;
    case (state)
      SCAN_SW:  begin raw = {22'b0, sw};  lat_cur = {22'b0, sw_lat};  end
      SCAN_KEY: begin raw = {28'b0, key}; lat_cur = {28'b0, key_lat}; end
      SCAN_AX:  begin raw = ax;           lat_cur = ax_lat;           end
      default:  begin raw = '0;           lat_cur = '0;               end
    endcase
  end

  // Counts are compared after this cycle's increment, so the entry sample
  // counts as the first stable one and a quiet port dwells DEB_CYCLES cycles.
  assign stab_inc  = stab_cnt + CNT_W'(1);
  assign dwell_inc = dwell_cnt + CNT_W'(1);
  assign commit    = !entry && (raw == cand) && (stab_inc == DEB_LAST);

  always_comb begin
    set_mask = 3'b000;
    if (commit && (cand != lat_cur)) begin
      case (state)
        SCAN_SW:  set_mask = 3'b001;
        SCAN_KEY: set_mask = 3'b010;
        SCAN_AX:  set_mask = 3'b100;
        default:  set_mask = 3'b000;
      endcase
    end
  end

  always_comb begin
    clr_mask = 3'b000;
    if (io_rd) begin
      case (addr[7:2])
        ADDR_SW:     clr_mask = 3'b001;
        ADDR_KEY:    clr_mask = 3'b010;
        ADDR_AX:     clr_mask = 3'b100;
        ADDR_STATUS: clr_mask = 3'b111;
        default:     clr_mask = 3'b000;
      endcase
    end
  end

  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      state     <= SCAN_SW;
      entry     <= 1'b1;
      cand      <= '0;
      stab_cnt  <= '0;
      dwell_cnt <= '0;
      sw_lat    <= '0;
      key_lat   <= '0;
      ax_lat    <= '0;
      io_chg    <= 3'b000;
    end else begin
      io_chg <= (io_chg & ~clr_mask) | set_mask;
      if (entry) begin
        cand      <= raw;
        stab_cnt  <= '0;
        dwell_cnt <= '0;
        entry     <= 1'b0;
      end else begin
        dwell_cnt <= dwell_inc;
        if (raw == cand) begin
          stab_cnt <= stab_inc;
        end else begin
          cand     <= raw;
          stab_cnt <= '0;
        end
        if (commit) begin
          case (state)
            SCAN_SW:  sw_lat  <= cand[9:0];
            SCAN_KEY: key_lat <= cand[3:0];
            SCAN_AX:  ax_lat  <= cand;
            default:  ;
          endcase
          state <= next_scan(state);
          entry <= 1'b1;
        end else if (dwell_inc == DWELL_LAST) begin
          state <= next_scan(state);
          entry <= 1'b1;
        end
      end
    end
  end

  io_read_mux u_read_mux (
    .addr_sel  (addr[7:2]),
    .sw_lat    (sw_lat),
    .key_lat   (key_lat),
    .ax_lat    (ax_lat),
    .chg       (io_chg),
    .read_data (io_read_data)
  );

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl: directed scenarios plus randomized traffic, all
// outputs compared against a sample-history reference model via a scoreboard.
module tb_io_input_ctrl;

  localparam int DEB   = 4;
  localparam int DWELL = 16;

  logic        io_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        io_rd  = 1'b0;
  logic [31:0] addr   = 32'h0;
  logic [9:0]  sw     = 10'h0;
  logic [3:0]  key    = 4'h0;
  logic [31:0] ax     = 32'h0;
  logic [31:0] io_read_data;
  logic [2:0]  io_chg;

  int total = 0;
  int bad   = 0;

  io_input_ctrl #(.DEB_CYCLES(DEB), .DWELL_MAX(DWELL)) dut (
    .io_clk       (io_clk),
    .resetn       (resetn),
    .addr         (addr),
    .io_rd        (io_rd),
    .sw           (sw),
    .key          (key),
    .ax           (ax),
    .io_read_data (io_read_data),
    .io_chg       (io_chg)
  );

  always #5 io_clk = ~io_clk;

  // Reference model: the samples taken from the current port since it was
  // entered; commit when the last DEB samples agree, give up after DWELL.
  int          m_port = 0;
  logic [31:0] m_hist[$];
  logic [31:0] m_lat[3] = '{default: 32'h0};
  logic [2:0]  m_chg = 3'b000;

  typedef struct packed {
    logic [31:0] rd;
    logic [2:0]  chg;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] m_read(input logic [5:0] a);
    case (a)
      6'b100000: return {22'b0, m_lat[0][9:0]};
      6'b100001: return {28'b0, m_lat[1][3:0]};
      6'b100100: return m_lat[2];
      6'b100101: return {29'b0, m_chg};
      default:   return 32'h0;
    endcase
  endfunction

  always @(posedge io_clk) begin
    logic [31:0] raw;
    logic [2:0]  clr;
    logic [2:0]  setm;
    bit          commit;
    if (!resetn) begin
      m_port = 0;
      m_hist.delete();
      m_lat  = '{default: 32'h0};
      m_chg  = 3'b000;
    end else begin
      clr = 3'b000;
      if (io_rd) begin
        case (addr[7:2])
          6'b100000: clr = 3'b001;
          6'b100001: clr = 3'b010;
          6'b100100: clr = 3'b100;
          6'b100101: clr = 3'b111;
          default:   clr = 3'b000;
        endcase
      end
      raw = (m_port == 0) ? {22'b0, sw} : (m_port == 1) ? {28'b0, key} : ax;
      m_hist.push_back(raw);
      commit = 1'b0;
      if (m_hist.size() >= DEB) begin
        commit = 1'b1;
        for (int i = 1; i < DEB; i++)
          if (m_hist[m_hist.size() - 1 - i] != raw) commit = 1'b0;
      end
      setm = 3'b000;
      if (commit) begin
        if (raw != m_lat[m_port]) setm[m_port] = 1'b1;
        m_lat[m_port] = raw;
        m_port = (m_port + 1) % 3;
        m_hist.delete();
      end else if (m_hist.size() == DWELL) begin
        m_port = (m_port + 1) % 3;
        m_hist.delete();
      end
      m_chg = (m_chg & ~clr) | setm;
    end
    sb.push_back('{rd: m_read(addr[7:2]), chg: m_chg});
  end

  always @(negedge io_clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (io_read_data !== e.rd || io_chg !== e.chg) begin
        bad++;
        $display("FAIL scoreboard t=%0t addr=%h: got rd=%h chg=%b, want rd=%h chg=%b",
                 $time, addr, io_read_data, io_chg, e.rd, e.chg);
      end
    end
  end

  task automatic tick();
    @(posedge io_clk);
    @(negedge io_clk);
    #1;
  endtask

  task automatic peek(input logic [31:0] a);
    addr = a;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  bit noisy;

  initial begin
    // Reset state
    resetn = 1'b0; sw = 10'h2A5; key = 4'h0; ax = 32'h0; addr = 32'h80;
    repeat (3) tick();
    peek(32'h80); chk("rst sw_lat", io_read_data, 32'h0);
    peek(32'h84); chk("rst key_lat", io_read_data, 32'h0);
    peek(32'h90); chk("rst ax_lat", io_read_data, 32'h0);
    tick();
    peek(32'h94); chk("rst status", io_read_data, 32'h0);
    chk("rst io_chg", {29'b0, io_chg}, 32'h0);

    // Stable sw commits on the 4th edge after release
    resetn = 1'b1; addr = 32'h80;
    repeat (3) tick();
    chk("sw early chg", {29'b0, io_chg}, 32'h0);
    chk("sw early lat", io_read_data, 32'h0);
    tick();
    chk("sw commit", io_read_data, 32'h000002A5);
    chk("sw chg", {29'b0, io_chg}, 32'h1);

    // Toggling sw is abandoned after DWELL cycles, key then commits
    resetn = 1'b0; tick();
    resetn = 1'b1; key = 4'h5; addr = 32'h84;
    for (int i = 0; i < 20; i++) begin
      sw = i[0] ? 10'h2AA : 10'h155;
      tick();
      if (i == 18) chk("key before commit", io_read_data, 32'h0);
    end
    chk("key after dwell", io_read_data, 32'h5);
    chk("chg after dwell", {29'b0, io_chg}, 32'h2);
    peek(32'h80); chk("sw_lat kept", io_read_data, 32'h0);

    // ax commit, status read then clear-all
    ax = 32'hDEADBEEF; sw = 10'h0; addr = 32'h84; io_rd = 1'b1;
    tick();
    io_rd = 1'b0;
    repeat (3) tick();
    peek(32'h94); chk("status ax only", io_read_data, 32'h4);
    io_rd = 1'b1;
    tick();
    io_rd = 1'b0;
    chk("status cleared", {29'b0, io_chg}, 32'h0);
    peek(32'h90); chk("ax_lat", io_read_data, 32'hDEADBEEF);

    // Key read during key commit: set wins
    key = 4'hA; addr = 32'h84; io_rd = 1'b1;
    repeat (7) tick();
    chk("set beats clear", {29'b0, io_chg}, 32'h2);
    chk("key_lat A", io_read_data, 32'hA);
    io_rd = 1'b0;

    // Reset mid key scan
    repeat (8) tick();
    key = 4'h3; tick();
    key = 4'hC; tick();
    key = 4'h3; resetn = 1'b0; tick();
    peek(32'h80); chk("midrst sw", io_read_data, 32'h0);
    peek(32'h84); chk("midrst key", io_read_data, 32'h0);
    peek(32'h90); chk("midrst ax", io_read_data, 32'h0);
    chk("midrst chg", {29'b0, io_chg}, 32'h0);
    resetn = 1'b1; sw = 10'h3; key = 4'h7; addr = 32'h80;
    repeat (3) tick();
    chk("post rst sw early", io_read_data, 32'h0);
    tick();
    chk("post rst sw first", io_read_data, 32'h3);
    peek(32'h84); chk("post rst key idle", io_read_data, 32'h0);

    // Unmapped read has no effect
    addr = 32'h0000000C; io_rd = 1'b1;
    #1; chk("unmapped rd", io_read_data, 32'h0);
    tick();
    io_rd = 1'b0;
    chk("unmapped chg", {29'b0, io_chg}, 32'h1);

    // Randomized traffic
    noisy = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) noisy = ($urandom_range(0, 2) == 0);
      if (noisy) begin
        sw = 10'($urandom); key = 4'($urandom); ax = $urandom;
      end else begin
        if ($urandom_range(0, 15) == 0) sw  = 10'($urandom);
        if ($urandom_range(0, 15) == 0) key = 4'($urandom);
        if ($urandom_range(0, 15) == 0) ax  = $urandom;
      end
      io_rd = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       addr = 32'h80;
        1:       addr = 32'h84;
        2:       addr = 32'h90;
        3:       addr = 32'h94;
        4:       addr = 32'h0C;
        default: addr = $urandom;
      endcase
      resetn = ($urandom_range(0, 299) != 0);
      tick();
    end
    io_rd = 1'b0; resetn = 1'b1;
    tick();
    chk("scoreboard drained", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_input_ctrl.md
IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4 (range 2..255), the consecutive stable samples required to commit a port value.
REQ-002 SHALL have parameter DWELL_MAX, default 4*DEB_CYCLES, the maximum cycles spent scanning one port before abandoning it.
REQ-003 SHALL have port io_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port addr, input, 32, CPU byte address; only addr[7:2] is decoded.
REQ-006 SHALL have port io_rd, input, 1, one-cycle CPU read strobe qualifying addr.
REQ-007 SHALL have port sw, input, 10, raw slide-switch bank.
REQ-008 SHALL have port key, input, 4, raw push-button bank.
REQ-009 SHALL have port ax, input, 32, raw external input word.
REQ-010 SHALL have port io_read_data, output, 32, combinational read data for addr.
REQ-011 SHALL have port io_chg, output, 3, {chg_ax, chg_key, chg_sw} change flags, registered.

Function
REQ-012 SHALL run a round-robin scan FSM with states SCAN_SW -> SCAN_KEY -> SCAN_AX -> SCAN_SW; no other states exist.
REQ-013 On the entry cycle of a state, SHALL load that port's raw value into cand, with stab_cnt=0 and dwell_cnt=0.
REQ-014 On each later cycle, if raw==cand SHALL increment stab_cnt; otherwise it SHALL reload cand from raw and clear stab_cnt.
REQ-015 When raw==cand and stab_cnt==DEB_CYCLES-1, SHALL at that edge write cand into the port's latched register and advance to the next state; a stable port therefore dwells exactly DEB_CYCLES cycles.
REQ-016 SHALL set the port's chg flag on commit only if cand differs from the previously latched value.
REQ-017 When dwell_cnt reaches DWELL_MAX-1 without a commit, SHALL advance to the next state with no latch write and no flag change.
REQ-018 SHALL decode addr[7:2] as: 6'b100000 -> {22'b0, sw_lat}; 6'b100001 -> {28'b0, key_lat}; 6'b100100 -> ax_lat; 6'b100101 -> {29'b0, io_chg}; any other value -> 32'h0.
REQ-019 io_rd=1 on a data address SHALL clear that port's chg flag at the next edge; io_rd=1 on the status address SHALL clear all three flags.
REQ-020 When a flag set and a flag clear target the same flag in the same cycle, set SHALL win.
REQ-021 io_read_data SHALL depend only on addr and the latched registers, with zero cycles of latency; a commit becomes visible the cycle after its edge.
REQ-022 io_rd with no addr decode match SHALL have no effect.

Reset
REQ-023 While resetn=0 at a rising edge, SHALL set state=SCAN_SW; sw_lat, key_lat, ax_lat, cand, stab_cnt and dwell_cnt to 0; and io_chg=3'b000. io_read_data then reads 0 for every address.
REQ-024 Reset asserted mid-scan SHALL abandon the scan with no partial commit; the first cycle after release SHALL be an SCAN_SW entry cycle.

Structure
REQ-025 A shared package io_pkg SHALL hold the FSM state enum, the four port address constants (6-bit) and the DEB_CYCLES default.
REQ-026 The read-data decode SHALL be one sub-module, io_read_mux (addr[7:2] plus three latched registers plus flags -> 32-bit word); the FSM, counters and flags SHALL stay in io_input_ctrl.

Verification
REQ-027 Reset release with sw=10'h2A5 held SHALL produce a commit at the 4th edge after release; a read of 0x...80 on the next cycle SHALL return 32'h000002A5, and io_chg SHALL equal 3'b001.
REQ-028 sw toggling every cycle for 20 cycles in SCAN_SW SHALL cause advance to SCAN_KEY after 16 cycles, with sw_lat and chg_sw unchanged.
REQ-029 ax=32'hDEADBEEF held, then a read of status with io_rd=1 after chg_ax sets, SHALL make status read 3'b100 and, the next cycle, io_chg=3'b000.
REQ-030 io_rd on the key address in the same cycle as a key commit with a new value SHALL leave chg_key at 1.
REQ-031 resetn pulled low for one cycle during SCAN_KEY with key changing SHALL leave all latched registers at 0 and the next state entry at SCAN_SW.
REQ-032 A read of an unmapped addr[7:2]=6'b000011 with io_rd=1 SHALL return 32'h0 and leave io_chg unchanged.
